ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register for the MIPS datapath, directly downstream of the ALU.
- Each cycle it captures the ALU result and 8-bit status, the store data, and the memory/writeback control bits.
- It decodes the status byte into precise exceptions (arithmetic overflow, misaligned load/store address) and squashes the faulting instruction.
- It raises a held exception request with cause/EPC/BadVAddr until the control unit acknowledges it.

Parameters:
- CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- EX_valid  in  1  EX stage holds a real instruction
- EX_pc  in  32  PC of the EX instruction
- EX_ALU_result  in  32  ALU result (also the memory address)
- EX_ALU_status  in  8  {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}, bit7..bit0
- EX_store_data  in  32  rt value for stores
- EX_mem_read  in  1  load
- EX_mem_write  in  1  store
- EX_reg_write  in  1  writes the register file
- EX_write_reg  in  5  destination register
- EX_ovf_trap_en  in  1  1 for add/sub/addi, 0 for the unsigned forms
- MEM_stall  in  1  MEM stage cannot accept
- MEM_flush  in  1  squash the instruction being captured
- EXC_ack  in  1  control unit accepted the exception
- EX_ready  out  1  stage accepts EX this cycle
- MEM_valid  out  1
- MEM_pc  out  32
- MEM_ALU_result  out  32
- MEM_store_data  out  32
- MEM_mem_read  out  1
- MEM_mem_write  out  1
- MEM_reg_write  out  1
- MEM_write_reg  out  5
- MEM_zero  out  1  captured status bit7
- EXC_req  out  1  exception pending
- EXC_cause  out  5  MIPS ExcCode
- EXC_epc  out  32  PC of the faulting instruction
- EXC_badvaddr  out  32  faulting address, or 0
- EXC_count  out  CNT_W  saturating count of exceptions taken

Behaviour:
- **Reset.**
  - Synchronous, active-high; takes priority over every other input, including mid-TRAP.
  - All outputs except EX_ready reset to 0. EX_ready = 1 after reset (state RUN, no stall).
  - State goes to RUN.
- **Latency.** One cycle from EX inputs to MEM_* outputs.
- **EX_ready.** Combinational: EX_ready = (state == RUN) && !MEM_stall.
- **Accept.** Accept = EX_ready && EX_valid.
- **Per-cycle priority** (highest first):
  1. reset
  2. MEM_flush
  3. state TRAP
  4. MEM_stall
  5. normal capture
- **MEM_flush.**
  - Next-cycle MEM_valid, mem_read, mem_write and reg_write are all 0; data fields are don't-care (held).
  - No exception is detected, so flush beats a simultaneous exception.
  - A flush in TRAP leaves the EXC_* registers and the state untouched.
- **MEM_stall** (RUN, no flush): all MEM_* registers hold their values; no exception detection.
- **Exception detection**, evaluated only on Accept. Priority:
  - overflow (bit6) && EX_ovf_trap_en -> cause 12 (Ov), badvaddr 0
  - invalid_address (bit3) && EX_mem_read -> cause 4 (AdEL), badvaddr = EX_ALU_result
  - invalid_address (bit3) && EX_mem_write -> cause 5 (AdES), badvaddr = EX_ALU_result
  - invalid_address with no memory op is ignored (arithmetic results are not addresses).
  - div_zero (bit2) is ignored and reserved.
- **On an exception:**
  - EXC_req <= 1, EXC_cause and EXC_badvaddr as above, EXC_epc <= EX_pc.
  - EXC_count increments, saturating at all-ones.
  - The faulting instruction is captured with MEM_valid, mem_read, mem_write and reg_write forced to 0, so it has no side effects.
  - State goes to TRAP.
- **Normal capture:**
  - MEM_valid <= EX_valid; all fields are copied.
  - Control bits are gated by EX_valid: if EX_valid = 0, mem_read, mem_write and reg_write capture 0.
- **State machine:**
  - RUN: normal operation as above; an accepted faulting instruction moves to TRAP.
  - TRAP: EX_ready = 0; MEM_valid, mem_read, mem_write and reg_write are driven 0 every cycle; EXC_* registers hold.
  - TRAP, EXC_ack = 1: EXC_req <= 0 and state <= RUN. The first new capture can occur the cycle after the ack.
  - EXC_ack in RUN is ignored.
  - A second exception cannot occur while in TRAP.
- **EXC_cause encoding.** 5 bits; unused values are never produced.

Test Plan:
- Reset, then EX_valid = 1, pc 0x00400000, result 0x10010004, status 0x00, reg_write 1, write_reg 8 -> next cycle MEM_valid 1, MEM_ALU_result 0x10010004, MEM_write_reg 8, EXC_req 0.
- Accept add with status 0x40 and ovf_trap_en 1 at pc 0x00400010 -> EXC_req 1, cause 12, epc 0x00400010, badvaddr 0, MEM_reg_write 0, EX_ready 0.
- Same instruction with ovf_trap_en 0 -> no exception, MEM_reg_write 1.
- Hold EXC_ack low 3 cycles, then pulse it -> state stays TRAP for 3 cycles, then EXC_req drops and EX_ready returns to 1.
- Load with result 0x10010002 and status 0x08 -> cause 4, badvaddr 0x10010002, MEM_mem_read 0.
- Store with result 0x10010001 and status 0x08 -> cause 5, badvaddr 0x10010001, MEM_mem_write 0.
- Same faulting load presented together with MEM_flush 1 -> EXC_req stays 0 and MEM_valid is 0.
- MEM_stall 1 for 2 cycles while EX changes -> MEM_* outputs hold their values, EX_ready 0.
- Assert reset while in TRAP -> next cycle EXC_req 0, EXC_count 0, EX_ready 1.
- Force 256 exceptions with CNT_W 8 -> EXC_count saturates at 0xFF.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the MIPS datapath. It captures ALU results and control bits,
// and it turns overflow or misaligned-address status into a precise, held exception request.
module ex_mem_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX_valid,
  input  logic [31:0]      EX_pc,
  input  logic [31:0]      EX_ALU_result,
  input  logic [7:0]       EX_ALU_status,
  input  logic [31:0]      EX_store_data,
  input  logic             EX_mem_read,
  input  logic             EX_mem_write,
  input  logic             EX_reg_write,
  input  logic [4:0]       EX_write_reg,
  input  logic             EX_ovf_trap_en,
  input  logic             MEM_stall,
  input  logic             MEM_flush,
  input  logic             EXC_ack,
  output logic             EX_ready,
  output logic             MEM_valid,
  output logic [31:0]      MEM_pc,
  output logic [31:0]      MEM_ALU_result,
  output logic [31:0]      MEM_store_data,
  output logic             MEM_mem_read,
  output logic             MEM_mem_write,
  output logic             MEM_reg_write,
  output logic [4:0]       MEM_write_reg,
  output logic             MEM_zero,
  output logic             EXC_req,
  output logic [4:0]       EXC_cause,
  output logic [31:0]      EXC_epc,
  output logic [31:0]      EXC_badvaddr,
  output logic [CNT_W-1:0] EXC_count
);

  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_OV   = 5'd12;

  typedef enum logic {RUN, TRAP} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        accept;
  logic        exc_ovf;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_hit;
  logic        exc_take;
  logic [4:0]  cause_next;
  logic [31:0] badvaddr_next;

  // Carry, negative, div_zero and the two low status bits play no part in this stage.
  logic unused_status;
  assign unused_status = ^{EX_ALU_status[5:4], EX_ALU_status[2:0]};

  assign accept   = EX_ready && EX_valid;
  assign exc_ovf  = EX_ALU_status[6] && EX_ovf_trap_en;
  assign exc_adel = EX_ALU_status[3] && EX_mem_read;
  assign exc_ades = EX_ALU_status[3] && EX_mem_write;
  assign exc_hit  = accept && (exc_ovf || exc_adel || exc_ades);
  // A flush squashes the instruction before it can fault.
  assign exc_take = exc_hit && !MEM_flush;

  always_comb begin
    cause_next    = CAUSE_ADES;
    badvaddr_next = EX_ALU_result;
    if (exc_ovf) begin
      cause_next    = CAUSE_OV;
      badvaddr_next = 32'h0;
    end else if (exc_adel) begin
      cause_next    = CAUSE_ADEL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (exc_take) state_next = TRAP;
      TRAP:    if (!MEM_flush && EXC_ack) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    EX_ready = (state_reg == RUN) && !MEM_stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MEM_valid      <= 1'b0;
      MEM_pc         <= 32'h0;
      MEM_ALU_result <= 32'h0;
      MEM_store_data <= 32'h0;
      MEM_mem_read   <= 1'b0;
      MEM_mem_write  <= 1'b0;
      MEM_reg_write  <= 1'b0;
      MEM_write_reg  <= 5'd0;
      MEM_zero       <= 1'b0;
      EXC_req        <= 1'b0;
      EXC_cause      <= 5'd0;
      EXC_epc        <= 32'h0;
      EXC_badvaddr   <= 32'h0;
      EXC_count      <= '0;
    end else if (MEM_flush || state_reg == TRAP) begin
      // Data fields hold; only the side-effect bits are cleared.
      MEM_valid     <= 1'b0;
      MEM_mem_read  <= 1'b0;
      MEM_mem_write <= 1'b0;
      MEM_reg_write <= 1'b0;
      if (!MEM_flush && EXC_ack) begin
        EXC_req <= 1'b0;
      end
    end else if (!MEM_stall) begin
      MEM_pc         <= EX_pc;
      MEM_ALU_result <= EX_ALU_result;
      MEM_store_data <= EX_store_data;
      MEM_write_reg  <= EX_write_reg;
      MEM_zero       <= EX_ALU_status[7];
      if (exc_hit) begin
        MEM_valid     <= 1'b0;
        MEM_mem_read  <= 1'b0;
        MEM_mem_write <= 1'b0;
        MEM_reg_write <= 1'b0;
        EXC_req       <= 1'b1;
        EXC_cause     <= cause_next;
        EXC_epc       <= EX_pc;
        EXC_badvaddr  <= badvaddr_next;
        if (EXC_count != '1) begin
          EXC_count <= EXC_count + CNT_W'(1);
        end
      end else begin
        MEM_valid     <= EX_valid;
        MEM_mem_read  <= EX_valid && EX_mem_read;
        MEM_mem_write <= EX_valid && EX_mem_write;
        MEM_reg_write <= EX_valid && EX_reg_write;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Table-driven bench for ex_mem_stage: each row drives one cycle of EX inputs and lists the
// MEM/EXC outputs expected after that edge; a scoreboard queue pairs drives with checks.
module tb_ex_mem_stage;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  typedef struct {
    string       name;
    logic        rst, valid;
    logic [31:0] pc, res;
    logic [7:0]  st;
    logic        rd, wr, rw;
    logic [4:0]  wreg;
    logic        ovf, stall, flush, ack;
    logic        e_valid, e_rd, e_wr, e_rw;
    logic [31:0] e_res;
    logic [4:0]  e_wreg;
    logic [31:0] e_mpc;
    logic        e_zero, e_req;
    logic [4:0]  e_cause;
    logic [31:0] e_epc, e_bad;
    logic [7:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, EX_valid, EX_mem_read, EX_mem_write, EX_reg_write, EX_ovf_trap_en;
  logic        MEM_stall, MEM_flush, EXC_ack;
  logic [31:0] EX_pc, EX_ALU_result, EX_store_data;
  logic [7:0]  EX_ALU_status;
  logic [4:0]  EX_write_reg;
  logic        EX_ready, MEM_valid, MEM_mem_read, MEM_mem_write, MEM_reg_write, MEM_zero, EXC_req;
  logic [31:0] MEM_pc, MEM_ALU_result, MEM_store_data, EXC_epc, EXC_badvaddr;
  logic [4:0]  MEM_write_reg, EXC_cause;
  logic [7:0]  EXC_count;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl[$];
  vec_t sb[$];

  ex_mem_stage #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .EX_valid(EX_valid), .EX_pc(EX_pc),
    .EX_ALU_result(EX_ALU_result), .EX_ALU_status(EX_ALU_status),
    .EX_store_data(EX_store_data), .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write),
    .EX_reg_write(EX_reg_write), .EX_write_reg(EX_write_reg), .EX_ovf_trap_en(EX_ovf_trap_en),
    .MEM_stall(MEM_stall), .MEM_flush(MEM_flush), .EXC_ack(EXC_ack), .EX_ready(EX_ready),
    .MEM_valid(MEM_valid), .MEM_pc(MEM_pc), .MEM_ALU_result(MEM_ALU_result),
    .MEM_store_data(MEM_store_data), .MEM_mem_read(MEM_mem_read), .MEM_mem_write(MEM_mem_write),
    .MEM_reg_write(MEM_reg_write), .MEM_write_reg(MEM_write_reg), .MEM_zero(MEM_zero),
    .EXC_req(EXC_req), .EXC_cause(EXC_cause), .EXC_epc(EXC_epc),
    .EXC_badvaddr(EXC_badvaddr), .EXC_count(EXC_count)
  );

  always #5 clk = ~clk;

  // Store data is the half-swapped result, so a zero result pairs with zero store data.
  function automatic logic [31:0] swap(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  function automatic vec_t mk(
    input string n, input logic rst, input logic valid, input logic [31:0] pc,
    input logic [31:0] res, input logic [7:0] st, input logic rd, input logic wr,
    input logic rw, input logic [4:0] wreg, input logic ovf, input logic stall,
    input logic flush, input logic ack,
    input logic ev, input logic erd, input logic ewr, input logic erw,
    input logic [31:0] eres, input logic [4:0] ewreg, input logic [31:0] empc,
    input logic ezero, input logic ereq, input logic [4:0] ecause,
    input logic [31:0] eepc, input logic [31:0] ebad, input logic [7:0] ecnt, input logic erdy);
    vec_t v;
    v.name = n; v.rst = rst; v.valid = valid; v.pc = pc; v.res = res; v.st = st;
    v.rd = rd; v.wr = wr; v.rw = rw; v.wreg = wreg; v.ovf = ovf; v.stall = stall;
    v.flush = flush; v.ack = ack;
    v.e_valid = ev; v.e_rd = erd; v.e_wr = ewr; v.e_rw = erw; v.e_res = eres;
    v.e_wreg = ewreg; v.e_mpc = empc; v.e_zero = ezero; v.e_req = ereq; v.e_cause = ecause;
    v.e_epc = eepc; v.e_bad = ebad; v.e_cnt = ecnt; v.e_rdy = erdy;
    return v;
  endfunction

  task automatic chk(input string v, input string f, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", v, f, act, exp);
    end
  endtask

  task automatic check(input vec_t e);
    vectors++;
    chk(e.name, "MEM_valid", 32'(MEM_valid), 32'(e.e_valid));
    chk(e.name, "MEM_mem_read", 32'(MEM_mem_read), 32'(e.e_rd));
    chk(e.name, "MEM_mem_write", 32'(MEM_mem_write), 32'(e.e_wr));
    chk(e.name, "MEM_reg_write", 32'(MEM_reg_write), 32'(e.e_rw));
    chk(e.name, "MEM_ALU_result", MEM_ALU_result, e.e_res);
    chk(e.name, "MEM_store_data", MEM_store_data, swap(e.e_res));
    chk(e.name, "MEM_write_reg", 32'(MEM_write_reg), 32'(e.e_wreg));
    chk(e.name, "MEM_pc", MEM_pc, e.e_mpc);
    chk(e.name, "MEM_zero", 32'(MEM_zero), 32'(e.e_zero));
    chk(e.name, "EXC_req", 32'(EXC_req), 32'(e.e_req));
    chk(e.name, "EXC_cause", 32'(EXC_cause), 32'(e.e_cause));
    chk(e.name, "EXC_epc", EXC_epc, e.e_epc);
    chk(e.name, "EXC_badvaddr", EXC_badvaddr, e.e_bad);
    chk(e.name, "EXC_count", 32'(EXC_count), 32'(e.e_cnt));
    chk(e.name, "EX_ready", 32'(EX_ready), 32'(e.e_rdy));
    $display("vec %0d %s: valid=%0b res=%08h req=%0b cause=%0d cnt=%0d ready=%0b",
             vectors, e.name, MEM_valid, MEM_ALU_result, EXC_req, EXC_cause, EXC_count, EX_ready);
  endtask

  task automatic drive(input vec_t v);
    vec_t e;
    reset = v.rst; EX_valid = v.valid; EX_pc = v.pc; EX_ALU_result = v.res;
    EX_ALU_status = v.st; EX_store_data = swap(v.res); EX_mem_read = v.rd;
    EX_mem_write = v.wr; EX_reg_write = v.rw; EX_write_reg = v.wreg;
    EX_ovf_trap_en = v.ovf; MEM_stall = v.stall; MEM_flush = v.flush; EXC_ack = v.ack;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sat;
    tbl.push_back(mk("reset", Y,N,32'h0,32'h0,8'h00,N,N,N,5'd0,N,N,N,N,
                     N,N,N,N,32'h0,5'd0,32'h0,N, N,5'd0,32'h0,32'h0,8'd0,Y));
    tbl.push_back(mk("alu", N,Y,32'h00400000,32'h10010004,8'h00,N,N,Y,5'd8,N,N,N,N,
                     Y,N,N,Y,32'h10010004,5'd8,32'h00400000,N, N,5'd0,32'h0,32'h0,8'd0,Y));
    tbl.push_back(mk("ovf_untrapped", N,Y,32'h00400010,32'h80000000,8'h40,N,N,Y,5'd9,N,N,N,N,
                     Y,N,N,Y,32'h80000000,5'd9,32'h00400010,N, N,5'd0,32'h0,32'h0,8'd0,Y));
    tbl.push_back(mk("ovf_trap", N,Y,32'h00400010,32'h80000000,8'h40,N,N,Y,5'd9,Y,N,N,N,
                     N,N,N,N,32'h80000000,5'd9,32'h00400010,N, Y,5'd12,32'h00400010,32'h0,8'd1,N));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("trap_wait", N,Y,32'h00400014,32'h00000011,8'h00,N,N,Y,5'd3,N,N,N,N,
                       N,N,N,N,32'h80000000,5'd9,32'h00400010,N, Y,5'd12,32'h00400010,32'h0,8'd1,N));
    tbl.push_back(mk("trap_ack", N,Y,32'h00400014,32'h00000011,8'h00,N,N,Y,5'd3,N,N,N,Y,
                     N,N,N,N,32'h80000000,5'd9,32'h00400010,N, N,5'd12,32'h00400010,32'h0,8'd1,Y));
    tbl.push_back(mk("post_ack", N,Y,32'h00400014,32'h00000011,8'h00,N,N,Y,5'd3,N,N,N,N,
                     Y,N,N,Y,32'h00000011,5'd3,32'h00400014,N, N,5'd12,32'h00400010,32'h0,8'd1,Y));
    tbl.push_back(mk("adel", N,Y,32'h00400020,32'h10010002,8'h08,Y,N,Y,5'd4,N,N,N,N,
                     N,N,N,N,32'h10010002,5'd4,32'h00400020,N, Y,5'd4,32'h00400020,32'h10010002,8'd2,N));
    tbl.push_back(mk("adel_ack", N,N,32'h0,32'h0,8'h00,N,N,N,5'd0,N,N,N,Y,
                     N,N,N,N,32'h10010002,5'd4,32'h00400020,N, N,5'd4,32'h00400020,32'h10010002,8'd2,Y));
    tbl.push_back(mk("ades", N,Y,32'h00400024,32'h10010001,8'h08,N,Y,N,5'd0,N,N,N,N,
                     N,N,N,N,32'h10010001,5'd0,32'h00400024,N, Y,5'd5,32'h00400024,32'h10010001,8'd3,N));
    tbl.push_back(mk("trap_flush_ack", N,N,32'h0,32'h0,8'h00,N,N,N,5'd0,N,N,Y,Y,
                     N,N,N,N,32'h10010001,5'd0,32'h00400024,N, Y,5'd5,32'h00400024,32'h10010001,8'd3,N));
    tbl.push_back(mk("ades_ack", N,N,32'h0,32'h0,8'h00,N,N,N,5'd0,N,N,N,Y,
                     N,N,N,N,32'h10010001,5'd0,32'h00400024,N, N,5'd5,32'h00400024,32'h10010001,8'd3,Y));
    tbl.push_back(mk("flush_adel", N,Y,32'h00400020,32'h10010002,8'h08,Y,N,Y,5'd4,N,N,Y,N,
                     N,N,N,N,32'h10010001,5'd0,32'h00400024,N, N,5'd5,32'h00400024,32'h10010001,8'd3,Y));
    tbl.push_back(mk("sw_ok", N,Y,32'h00400030,32'h10010008,8'h80,N,Y,N,5'd0,N,N,N,N,
                     Y,N,Y,N,32'h10010008,5'd0,32'h00400030,Y, N,5'd5,32'h00400024,32'h10010001,8'd3,Y));
    tbl.push_back(mk("stall1", N,Y,32'h00400034,32'h00000055,8'h00,N,N,Y,5'd7,N,Y,N,N,
                     Y,N,Y,N,32'h10010008,5'd0,32'h00400030,Y, N,5'd5,32'h00400024,32'h10010001,8'd3,N));
    tbl.push_back(mk("stall2_ovf", N,Y,32'h00400038,32'h00000066,8'h40,N,N,Y,5'd7,Y,Y,N,N,
                     Y,N,Y,N,32'h10010008,5'd0,32'h00400030,Y, N,5'd5,32'h00400024,32'h10010001,8'd3,N));
    tbl.push_back(mk("bubble", N,N,32'h0040003C,32'h00000077,8'h00,N,N,Y,5'd6,N,N,N,N,
                     N,N,N,N,32'h00000077,5'd6,32'h0040003C,N, N,5'd5,32'h00400024,32'h10010001,8'd3,Y));
    tbl.push_back(mk("addr_no_memop", N,Y,32'h00400040,32'h00000013,8'h08,N,N,Y,5'd2,N,N,N,N,
                     Y,N,N,Y,32'h00000013,5'd2,32'h00400040,N, N,5'd5,32'h00400024,32'h10010001,8'd3,Y));
    tbl.push_back(mk("divzero_ignored", N,Y,32'h00400044,32'h00000014,8'h04,N,N,Y,5'd1,N,N,N,N,
                     Y,N,N,Y,32'h00000014,5'd1,32'h00400044,N, N,5'd5,32'h00400024,32'h10010001,8'd3,Y));
    tbl.push_back(mk("ovf_trap2", N,Y,32'h00400048,32'h00000007,8'h40,N,N,Y,5'd5,Y,N,N,N,
                     N,N,N,N,32'h00000007,5'd5,32'h00400048,N, Y,5'd12,32'h00400048,32'h0,8'd4,N));
    tbl.push_back(mk("reset_in_trap", Y,Y,32'h00400050,32'h00000009,8'h40,N,N,Y,5'd1,Y,N,N,N,
                     N,N,N,N,32'h0,5'd0,32'h0,N, N,5'd0,32'h0,32'h0,8'd0,Y));

    foreach (tbl[i]) drive(tbl[i]);

    // Counter saturation: 257 trap/ack pairs, the count must stop at 0xFF.
    for (int i = 0; i < 257; i++) begin
      sat = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
      drive(mk("sat_trap", N,Y,32'h00400100,32'h00000007,8'h40,N,N,Y,5'd5,Y,N,N,N,
               N,N,N,N,32'h00000007,5'd5,32'h00400100,N, Y,5'd12,32'h00400100,32'h0,sat,N));
      drive(mk("sat_ack", N,N,32'h0,32'h0,8'h00,N,N,N,5'd0,N,N,N,Y,
               N,N,N,N,32'h00000007,5'd5,32'h00400100,N, N,5'd12,32'h00400100,32'h0,sat,Y));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
